clint_timer_arm: RTL and testbench

//  Bus initiator that programs a per-hart machine timer compare on the CLINT register bus (valid/ready, SiFive map).
//  On an arm request it atomically reads 64-bit mtime, computes target = mtime + delta and writes mtimecmp[hart].
//  It uses the glitch-free hi/lo/hi sequence, so firmware or a hardware scheduler can arm a timeout without software races.

---
 rtl/clint_timer_arm.sv | 205 ++++++++++++++++++++
 tb/tb_clint_timer_arm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer_arm.sv
// Arms a CLINT machine-timer compare: reads 64-bit mtime with the hi/lo/hi
// sequence, adds a delta (saturating) and writes mtimecmp[hart] without an early mtip.
module clint_timer_arm #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                N_CORES   = 1,
  parameter int                HART_W    = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm_valid,
  output logic                arm_ready,
  input  logic [HART_W-1:0]   arm_hart,
  input  logic [63:0]         arm_delta,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [63:0]         target,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready,
  output logic [3:0]          dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_HI1, S_RD_LO, S_RD_HI2, S_CALC,
    S_WR_HI_MAX, S_WR_LO, S_WR_HI, S_DRAIN, S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0]   MTIME_LO = BASE_ADDR + ADDR_W'(32'hBFF8);
  localparam logic [ADDR_W-1:0]   MTIME_HI = BASE_ADDR + ADDR_W'(32'hBFFC);
  localparam logic [7:0]          TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [DATA_W/8-1:0] STRB_WR  = '1;

  state_t              state_q, next_q;
  logic [HART_W-1:0]   hart_q;
  logic [63:0]         delta_q;
  logic [31:0]         hi1_q, lo_q;
  logic [63:0]         tgt_q, target_q;
  logic                err_q, done_q, error_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   address_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [7:0]          cnt_q;

  logic                accept, hart_ok;
  logic                launch_d;
  state_t              launch_st_d, step_d;
  logic [ADDR_W-1:0]   cmp_lo, cmp_hi, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_d;
  logic [DATA_W/8-1:0] req_wstrb_d;
  logic [64:0]         sum_d;

  assign accept  = arm_valid && (state_q == S_IDLE);
  assign hart_ok = (32'(arm_hart) < 32'(N_CORES));
  assign cmp_lo  = BASE_ADDR + ADDR_W'(32'h4000) + (ADDR_W'(hart_q) << 3);
  assign cmp_hi  = cmp_lo + ADDR_W'(4);
  assign sum_d   = {1'b0, hi1_q, lo_q} + {1'b0, delta_q};

  // Successor of the current bus step once its response has arrived.
  always_comb begin
    step_d = S_IDLE;
    case (state_q)
      S_RD_HI1:    step_d = S_RD_LO;
      S_RD_LO:     step_d = S_RD_HI2;
      S_RD_HI2:    step_d = (rdata[31:0] == hi1_q) ? S_CALC : S_RD_LO;
      S_WR_HI_MAX: step_d = S_WR_LO;
      S_WR_LO:     step_d = S_WR_HI;
      S_WR_HI:     step_d = S_FIN;
      default:     step_d = S_IDLE;
    endcase
  end

  // A new bus request is issued on the same edge its state is entered.
  always_comb begin
    launch_d    = 1'b0;
    launch_st_d = S_IDLE;
    case (state_q)
      S_IDLE:  if (accept && hart_ok) begin
                 launch_d    = 1'b1;
                 launch_st_d = S_RD_HI1;
               end
      S_DRAIN: if (!ready && (next_q inside {S_RD_LO, S_RD_HI2, S_WR_LO, S_WR_HI})) begin
                 launch_d    = 1'b1;
                 launch_st_d = next_q;
               end
      S_CALC:  begin
                 launch_d    = 1'b1;
                 launch_st_d = S_WR_HI_MAX;
               end
      default: ;
    endcase
  end

  always_comb begin
    req_addr_d  = MTIME_HI;
    req_wdata_d = '0;
    req_wstrb_d = '0;
    case (launch_st_d)
      S_RD_LO:     req_addr_d = MTIME_LO;
      S_WR_HI_MAX: begin
                     req_addr_d  = cmp_hi;
                     req_wdata_d = '1;
                     req_wstrb_d = STRB_WR;
                   end
      S_WR_LO:     begin
                     req_addr_d  = cmp_lo;
                     req_wdata_d = DATA_W'(tgt_q[31:0]);
                     req_wstrb_d = STRB_WR;
                   end
      S_WR_HI:     begin
                     req_addr_d  = cmp_hi;
                     req_wdata_d = DATA_W'(tgt_q[63:32]);
                     req_wstrb_d = STRB_WR;
                   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      next_q    <= S_IDLE;
      hart_q    <= '0;
      delta_q   <= '0;
      hi1_q     <= '0;
      lo_q      <= '0;
      tgt_q     <= '0;
      target_q  <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (launch_d) begin
        valid_q   <= 1'b1;
        address_q <= req_addr_d;
        wdata_q   <= req_wdata_d;
        wstrb_q   <= req_wstrb_d;
        cnt_q     <= '0;
      end
      case (state_q)
        S_IDLE: if (accept) begin
          hart_q  <= arm_hart;
          delta_q <= arm_delta;
          err_q   <= !hart_ok;
          state_q <= hart_ok ? S_RD_HI1 : S_FIN;
        end
        S_RD_HI1, S_RD_LO, S_RD_HI2, S_WR_HI_MAX, S_WR_LO, S_WR_HI: begin
          if (ready) begin
            valid_q <= 1'b0;
            state_q <= S_DRAIN;
            next_q  <= step_d;
            if (state_q == S_RD_HI1) hi1_q <= rdata[31:0];
            if (state_q == S_RD_LO)  lo_q  <= rdata[31:0];
            if (state_q == S_RD_HI2) hi1_q <= rdata[31:0];
          end else if (cnt_q == TO_LAST) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
            next_q  <= S_FIN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DRAIN: if (!ready) state_q <= next_q;
        S_CALC: begin
          tgt_q   <= sum_d[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum_d[63:0];
          state_q <= S_WR_HI_MAX;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          error_q <= err_q;
          if (!err_q) target_q <= tgt_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arm_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign target      = target_q;
  assign valid       = valid_q;
  assign address     = address_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clint_timer_arm.sv
// Bench for clint_timer_arm: scripted mtime responder, transaction-level model
// of the expected bus traffic and result, and a per-cycle output compare.
module tb_clint_timer_arm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm_valid;
  logic        arm_ready;
  logic [1:0]  arm_hart;
  logic [63:0] arm_delta;
  logic        busy, done, error;
  logic [63:0] target;
  logic        valid;
  logic [31:0] address, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [3:0]  dbg_state;

  clint_timer_arm #(
    .ADDR_W(32), .DATA_W(32), .N_CORES(2), .HART_W(2), .BASE_ADDR(32'h0), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_hart(arm_hart), .arm_delta(arm_delta),
    .busy(busy), .done(done), .error(error), .target(target),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] script[$];
  logic [31:0] rd_q[$];
  logic [67:0] obs_q[$];
  logic [67:0] exp_q[$];
  int          lat_g = 0, hold_g = 0, stall_cnt = 0;
  bit          stall_g = 1'b0;
  logic        exp_err = 1'b0;
  logic [63:0] exp_tgt = '0;
  logic [63:0] hold_tgt = '0;
  int          exp_done_total = 0, done_cnt = 0, valid_cycles = 0;

  function automatic void chk(string name, logic [67:0] act, logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Bus responder: answers after lat_g cycles, holds ready for 1+hold_g cycles,
  // and never answers the hart-0 low compare write while stall_g is set.
  initial begin : responder
    int wait_cnt;
    int hold_left;
    wait_cnt  = 0;
    hold_left = 0;
    ready     = 1'b0;
    rdata     = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        ready    = 1'b0;
        wait_cnt = 0;
      end else if (ready) begin
        if (hold_left > 0) hold_left--;
        else ready = 1'b0;
      end else if (valid) begin
        if (stall_g && wstrb == 4'hF && address == 32'h4000) begin
          stall_cnt++;
        end else if (wait_cnt < lat_g) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          obs_q.push_back({wstrb, address, (wstrb == 4'hF) ? wdata : 32'h0});
          if (wstrb == 4'h0) rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
          ready     = 1'b1;
          hold_left = hold_g;
        end
      end
    end
  end

  // Scoreboard: per-cycle checks of handshake/status outputs and target hold.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_tgt = '0;
        continue;
      end
      if (valid) valid_cycles++;
      if (done) begin
        done_cnt++;
        chk("done_expected", 68'(done_cnt <= exp_done_total), 68'(1));
        chk("error_with_done", 68'(error), 68'(exp_err));
        if (!exp_err) hold_tgt = exp_tgt;
      end
      chk("target_hold", 68'(target), 68'(hold_tgt));
      if (done_cnt >= exp_done_total) begin
        chk("idle_busy", 68'(busy), 68'(0));
        chk("idle_arm_ready", 68'(arm_ready), 68'(1));
        chk("idle_valid", 68'(valid), 68'(0));
      end else begin
        chk("seq_busy", 68'(busy), 68'(1));
        chk("seq_arm_ready", 68'(arm_ready), 68'(0));
      end
    end
  end

  // Model: expected bus transactions and result from the mtime script.
  task automatic build_exp(input logic [1:0] hart, input logic [63:0] delta, input bit stall);
    logic [31:0] hi, lo, h2, cmp;
    logic [63:0] mt;
    int          i;
    exp_q.delete();
    exp_err = 1'b0;
    exp_tgt = '0;
    if (hart >= 2'd2) begin
      exp_err = 1'b1;
      return;
    end
    lo = '0;
    hi = script[0];
    i  = 1;
    exp_q.push_back({4'h0, 32'hBFFC, 32'h0});
    while (i + 1 < script.size()) begin
      exp_q.push_back({4'h0, 32'hBFF8, 32'h0});
      lo = script[i];
      exp_q.push_back({4'h0, 32'hBFFC, 32'h0});
      h2 = script[i+1];
      i += 2;
      if (h2 == hi) break;
      hi = h2;
    end
    mt      = {hi, lo};
    exp_tgt = (mt > ~delta) ? 64'hFFFF_FFFF_FFFF_FFFF : mt + delta;
    cmp     = 32'h4000 + 32'(hart) * 32'd8;
    exp_q.push_back({4'hF, cmp + 32'd4, 32'hFFFF_FFFF});
    if (stall) begin
      exp_err = 1'b1;
    end else begin
      exp_q.push_back({4'hF, cmp, exp_tgt[31:0]});
      exp_q.push_back({4'hF, cmp + 32'd4, exp_tgt[63:32]});
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_done_total = done_cnt;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic arm_start(input logic [1:0] hart, input logic [63:0] delta);
    @(posedge clk); #2;
    arm_valid = 1'b1;
    arm_hart  = hart;
    arm_delta = delta;
    @(posedge clk); #2;
    arm_valid = 1'b0;
    exp_done_total++;
  endtask

  task automatic arm_finish(output int waited);
    waited = 0;
    while (done_cnt < exp_done_total && waited < 2000) begin
      @(negedge clk); #1;
      waited++;
    end
    if (done_cnt < exp_done_total) begin
      chk("done_timeout", 68'(done_cnt), 68'(exp_done_total));
      do_reset();
    end
    chk("txn_count", 68'(obs_q.size()), 68'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk($sformatf("txn%0d", i), obs_q[i], exp_q[i]);
  endtask

  task automatic setup_arm(input logic [1:0] hart, input logic [63:0] delta,
                           input int lat, input int hold, input bit stall);
    lat_g     = lat;
    hold_g    = hold;
    stall_g   = stall;
    stall_cnt = 0;
    obs_q.delete();
    rd_q = script;
    build_exp(hart, delta, stall);
  endtask

  task automatic run_arm(input logic [1:0] hart, input logic [63:0] delta,
                         input int lat, input int hold, input bit stall, output int waited);
    setup_arm(hart, delta, lat, hold, stall);
    arm_start(hart, delta);
    arm_finish(waited);
  endtask

  initial begin : driver
    int waited;
    int vc0;
    reset_n   = 1'b0;
    arm_valid = 1'b0;
    arm_hart  = '0;
    arm_delta = '0;
    @(posedge clk); #2;
    chk("rst_arm_ready", 68'(arm_ready), 68'(1));
    chk("rst_busy", 68'(busy), 68'(0));
    chk("rst_done", 68'(done), 68'(0));
    chk("rst_error", 68'(error), 68'(0));
    chk("rst_target", 68'(target), 68'(0));
    chk("rst_bus", {wstrb, address, wdata}, 68'(0));
    chk("rst_valid", 68'(valid), 68'(0));
    @(posedge clk); #2 reset_n = 1'b1;

    // plain arm
    script = '{32'h0, 32'h1000, 32'h0};
    run_arm(2'd0, 64'h100, 0, 0, 1'b0, waited);
    chk("t1_target", 68'(target), 68'(64'h1100));
    chk("t1_ntxn", 68'(obs_q.size()), 68'(6));
    if (obs_q.size() == 6) begin
      chk("t1_wr_hi_max", obs_q[3], {4'hF, 32'h4004, 32'hFFFF_FFFF});
      chk("t1_wr_lo", obs_q[4], {4'hF, 32'h4000, 32'h0000_1100});
      chk("t1_wr_hi", obs_q[5], {4'hF, 32'h4004, 32'h0000_0000});
    end

    // hi word changes between reads: lo must be re-read
    script = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h1};
    run_arm(2'd0, 64'h10, 1, 0, 1'b0, waited);
    chk("t2_target", 68'(target), 68'(64'h1_0000_0015));
    chk("t2_ntxn", 68'(obs_q.size()), 68'(8));

    // saturation; ready held high to exercise drain
    script = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    run_arm(2'd0, 64'h20, 0, 2, 1'b0, waited);
    chk("t3_target", 68'(target), 68'(64'hFFFF_FFFF_FFFF_FFFF));
    if (obs_q.size() == 6) begin
      chk("t3_wr_hi_max", obs_q[3], {4'hF, 32'h4004, 32'hFFFF_FFFF});
      chk("t3_wr_hi", obs_q[5], {4'hF, 32'h4004, 32'hFFFF_FFFF});
    end

    // bad hart: no bus activity, done one cycle after FIN
    vc0 = valid_cycles;
    script.delete();
    run_arm(2'd3, 64'h1, 0, 0, 1'b0, waited);
    chk("t4_latency", 68'(waited), 68'(2));
    chk("t4_ntxn", 68'(obs_q.size()), 68'(0));
    chk("t4_no_valid", 68'(valid_cycles - vc0), 68'(0));
    chk("t4_target_kept", 68'(target), 68'(64'hFFFF_FFFF_FFFF_FFFF));

    // hart 1 with slow responder
    script = '{32'h12, 32'h3456_7890, 32'h12};
    run_arm(2'd1, 64'hABCD, 3, 1, 1'b0, waited);
    chk("t4b_target", 68'(target), 68'(64'h12_3457_245D));

    // timeout on the low compare write
    script = '{32'h0, 32'h2000, 32'h0};
    run_arm(2'd0, 64'h5, 0, 0, 1'b1, waited);
    chk("t5_stall_cycles", 68'(stall_cnt), 68'(255));
    chk("t5_ntxn", 68'(obs_q.size()), 68'(4));
    chk("t5_target_kept", 68'(target), 68'(64'h12_3457_245D));

    // async reset while reading mtime lo
    script = '{32'h0, 32'h1000, 32'h0};
    setup_arm(2'd0, 64'h100, 2, 0, 1'b0);
    arm_start(2'd0, 64'h100);
    waited = 0;
    while (!(valid && address == 32'hBFF8) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("t6_reached_rd_lo", 68'(valid && address == 32'hBFF8), 68'(1));
    #2 reset_n = 1'b0;
    exp_done_total = done_cnt;
    #1;
    chk("t6_valid", 68'(valid), 68'(0));
    chk("t6_busy", 68'(busy), 68'(0));
    chk("t6_arm_ready", 68'(arm_ready), 68'(1));
    chk("t6_done", 68'(done), 68'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    script = '{32'h3, 32'h0, 32'h3};
    run_arm(2'd0, 64'h7, 0, 0, 1'b0, waited);
    chk("t7_target", 68'(target), 68'(64'h3_0000_0007));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
